despertador_buzzer_tone: RTL and testbench

Memory-mapped multi-channel buzzer driver for the alarm-clock CPU system. It sits on the processor's Avalon-MM data bus as a 4-word slave. It drives `N_CH` buzzer outputs either as static levels or as a square-wave tone with an optional on/off beep cadence. Its register 0 keeps the behaviour of a plain output port, so existing static-level firmware needs no change.

---
 rtl/despertador_buzzer_tone.sv | 215 +++++++++++++++++++++
 tb/tb_despertador_buzzer_tone.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/despertador_buzzer_tone.sv
// -----------------------------------------------------------------------------
// despertador_buzzer_tone
//
// Avalon-MM 4-word slave that drives N_CH buzzer outputs, either as static
// levels or as a square-wave tone gated by an optional ON/OFF beep cadence.
// Word 0 behaves like a plain output port so static-level firmware is unchanged.
//
// Register map (word addresses):
//   0 DATA : [N_CH-1:0]        channel enable / static level
//   1 CTRL : bit0 TONE_EN, bit1 CAD_EN
//   2 HALF : [DIV_WIDTH-1:0]   tone half-period minus 1
//   3 CAD  : ON_CNT [CAD_WIDTH-1:0], OFF_CNT [CAD_WIDTH+15:16]
//
// Ports:
//   clk        system clock (single domain)
//   reset      asynchronous, active-high reset
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe (write = chipselect && !write_n)
//   writedata  write data
//   readdata   combinational read data, zero wait states, unused bits 0
//   out_port   registered buzzer drive
// -----------------------------------------------------------------------------
module despertador_buzzer_tone #(
    parameter int N_CH      = 1,
    parameter int DIV_WIDTH = 16,
    parameter int CAD_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [N_CH-1:0]      out_port
);

    typedef enum logic {
        ST_ON  = 1'b0,
        ST_OFF = 1'b1
    } cad_state_t;

    // Programmable registers
    logic [N_CH-1:0]      data_reg;
    logic                 tone_en;
    logic                 cad_en;
    logic [DIV_WIDTH-1:0] half;
    logic [CAD_WIDTH-1:0] on_cnt;
    logic [CAD_WIDTH-1:0] off_cnt;

    // Tone divider and cadence state
    logic [DIV_WIDTH-1:0] cnt;
    logic                 phase;
    logic [CAD_WIDTH-1:0] pcnt;
    logic [CAD_WIDTH-1:0] pcnt_next;
    cad_state_t           state;
    cad_state_t           state_next;
    logic                 gate;

    // Write decode
    logic wr_en;
    logic wr_data;
    logic wr_ctrl;
    logic wr_half;
    logic wr_cad;
    logic tone_start;
    logic div_clear;
    logic cad_restart;
    logic toggle;
    logic period_done;
    logic unused_wdata;

    assign wr_en   = chipselect && !write_n;
    assign wr_data = wr_en && (address == 2'd0);
    assign wr_ctrl = wr_en && (address == 2'd1);
    assign wr_half = wr_en && (address == 2'd2);
    assign wr_cad  = wr_en && (address == 2'd3);

    // Only a 0->1 transition of TONE_EN restarts the tone; rewriting 1 does not.
    assign tone_start  = wr_ctrl && writedata[0] && !tone_en;
    assign div_clear   = tone_start || wr_half;
    assign cad_restart = tone_start || wr_cad;

    // A register-write clear suppresses the same-cycle toggle, and with it any
    // period completion the toggle would have signalled to the cadence FSM.
    assign toggle      = tone_en && !div_clear && (cnt == half);
    assign period_done = toggle && phase;

    // Sinks write-data bits that no register stores.
    assign unused_wdata = ^writedata;

    // Register file
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
            tone_en  <= 1'b0;
            cad_en   <= 1'b0;
            half     <= '0;
            on_cnt   <= '0;
            off_cnt  <= '0;
        end else begin
            if (wr_data) data_reg <= writedata[N_CH-1:0];
            if (wr_ctrl) begin
                tone_en <= writedata[0];
                cad_en  <= writedata[1];
            end
            if (wr_half) half <= writedata[DIV_WIDTH-1:0];
            if (wr_cad) begin
                on_cnt  <= writedata[CAD_WIDTH-1:0];
                off_cnt <= writedata[CAD_WIDTH+15:16];
            end
        end
    end

    // Tone divider: cnt runs 0..HALF, phase toggles on wrap; frozen while off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (div_clear) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tone_en) begin
            if (toggle) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + DIV_WIDTH'(1);
            end
        end
    end

    // Cadence FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_ON;
            pcnt  <= '0;
        end else begin
            state <= state_next;
            pcnt  <= pcnt_next;
        end
    end

    // Cadence FSM: next state. pcnt counts completed tone periods in the
    // current state; the last period of a state hands over with pcnt cleared.
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    always_comb begin
        state_next = state;
        pcnt_next  = pcnt;
        if (cad_restart || !cad_en) begin
            state_next = ST_ON;
            pcnt_next  = '0;
        end else if (period_done) begin
            case (state)
                ST_ON: begin
                    if (pcnt == on_cnt) begin
                        state_next = ST_OFF;
                        pcnt_next  = '0;
                    end else begin
                        pcnt_next = pcnt + CAD_WIDTH'(1);
                    end
                end
                ST_OFF: begin
                    if (pcnt == off_cnt) begin
                        state_next = ST_ON;
                        pcnt_next  = '0;
                    end else begin
                        pcnt_next = pcnt + CAD_WIDTH'(1);
                    end
                end
                default: begin
                    state_next = ST_ON;
                    pcnt_next  = '0;
                end
            endcase
        end
    end

    // Cadence FSM: output
    always_comb begin
        gate = (state == ST_ON);
    end

    // Buzzer drive. Clears asynchronously so a reset silences the buzzer
    // immediately rather than on the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port <= '0;
        end else if (tone_en) begin
            out_port <= data_reg & {N_CH{phase & gate}};
        end else begin
            out_port <= data_reg;
        end
    end

    // Read mux: registers read back as written, masked to width.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[N_CH-1:0]      = data_reg;
            2'd1: readdata[1:0]           = {cad_en, tone_en};
            2'd2: readdata[DIV_WIDTH-1:0] = half;
            2'd3: begin
                readdata[CAD_WIDTH-1:0]     = on_cnt;
                readdata[CAD_WIDTH+15:16]   = off_cnt;
            end
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_despertador_buzzer_tone.sv
// -----------------------------------------------------------------------------
// tb_despertador_buzzer_tone
//
// Self-checking bench for despertador_buzzer_tone (N_CH=4). A behavioural
// model tracks elapsed enabled cycles since the last divider restart and
// completed tone periods since the last cadence restart; tone phase and
// cadence gate are derived from those with plain division and modulo.
// -----------------------------------------------------------------------------
module tb_despertador_buzzer_tone;

    localparam int N_CH      = 4;
    localparam int DIV_WIDTH = 16;
    localparam int CAD_WIDTH = 8;
    localparam logic [31:0] CH_MASK = 32'h0000_000F;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        address = 2'd0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = 32'd0;
    logic [31:0]       readdata;
    logic [N_CH-1:0]   out_port;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    despertador_buzzer_tone #(
        .N_CH      (N_CH),
        .DIV_WIDTH (DIV_WIDTH),
        .CAD_WIDTH (CAD_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // ---------------------------------------------------------------- model
    logic [31:0] m_data = 0, m_half = 0, m_on = 0, m_off = 0, m_out = 0;
    logic        m_tone = 0, m_cad = 0;
    longint      div_t = 0;   // enabled cycles since divider restart
    longint      per_t = 0;   // completed tone periods since cadence restart
    logic        m_wr, m_start, m_hw, m_cw, m_done, m_ph, m_g;
    longint      m_per;

    function automatic logic model_gate();
        return (per_t % (longint'(m_on) + longint'(m_off) + 2)) < (longint'(m_on) + 1);
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_data;
            2'd1:    return {30'd0, m_cad, m_tone};
            2'd2:    return m_half;
            default: return (m_off << 16) | m_on;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data = 0; m_half = 0; m_on = 0; m_off = 0; m_out = 0;
            m_tone = 0; m_cad = 0; div_t = 0; per_t = 0;
        end else begin
            m_wr    = chipselect && !write_n;
            m_start = m_wr && address == 2'd1 && writedata[0] && !m_tone;
            m_hw    = m_wr && address == 2'd2;
            m_cw    = m_wr && address == 2'd3;
            m_per   = 2 * (longint'(m_half) + 1);
            m_ph    = ((div_t / (longint'(m_half) + 1)) % 2) == 1;
            m_g     = model_gate();
            m_out   = m_tone ? (m_data & ((m_ph && m_g) ? CH_MASK : 32'd0)) : m_data;
            m_done  = m_tone && !m_start && !m_hw && ((div_t + 1) % m_per == 0);
            if (m_start || m_hw) div_t = 0;
            else if (m_tone)     div_t = div_t + 1;
            if (m_start || m_cw) per_t = 0;
            else if (!m_cad)     per_t = 0;
            else if (m_done)     per_t = per_t + 1;
            if (m_wr) begin
                case (address)
                    2'd0: m_data = writedata & CH_MASK;
                    2'd1: begin m_tone = writedata[0]; m_cad = writedata[1]; end
                    2'd2: m_half = writedata & 32'h0000_FFFF;
                    default: begin
                        m_on  = writedata & 32'h0000_00FF;
                        m_off = (writedata >> 16) & 32'h0000_00FF;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        chipselect = 1'b0; write_n = 1'b1; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_port !== 4'h0) begin
            n_bad++; $display("FAIL reset_out: out_port=%h expected 0", out_port);
        end
        for (int a = 0; a < 4; a++) begin
            address = a[1:0]; #1;
            n_cmp++;
            if (readdata !== 32'd0) begin
                n_bad++; $display("FAIL reset_read a%0d: readdata=%h expected 0", a, readdata);
            end
        end
    endtask

    task automatic test_static();
        wr(2'd0, 32'hFFFF_FFFA);
        n_cmp++;
        if (out_port !== 4'h0) begin
            n_bad++; $display("FAIL static_edgeE: out_port=%h expected 0", out_port);
        end
        @(negedge clk);
        n_cmp++;
        if (out_port !== 4'hA) begin
            n_bad++; $display("FAIL static_edgeE1: out_port=%h expected a", out_port);
        end
        address = 2'd0; #1;
        n_cmp++;
        if (readdata !== 32'h0000_000A) begin
            n_bad++; $display("FAIL static_read: readdata=%h expected 0000000a", readdata);
        end
    endtask

    task automatic test_tone_half0();
        logic [3:0] exp;
        wr(2'd0, 32'hF); wr(2'd2, 32'd0); wr(2'd1, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = (k % 2 == 0) ? 4'hF : 4'h0;
            n_cmp++;
            if (out_port !== exp) begin
                n_bad++; $display("FAIL tone_h0 k%0d: out_port=%h expected %h", k, out_port, exp);
            end
        end
        wr(2'd1, 32'd0);
        @(negedge clk);
        n_cmp++;
        if (out_port !== 4'hF) begin
            n_bad++; $display("FAIL tone_h0_stop: out_port=%h expected f", out_port);
        end
    endtask

    task automatic test_period();
        logic [3:0] exp;
        wr(2'd2, 32'd4); wr(2'd1, 32'd1);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            exp = (((k - 1) / 5) % 2 == 1) ? 4'hF : 4'h0;
            n_cmp++;
            if (out_port !== exp) begin
                n_bad++; $display("FAIL period_h4 k%0d: out_port=%h expected %h", k, out_port, exp);
            end
        end
        // Out has been high one cycle: rewrite HALF=2 in the middle of the high.
        wr(2'd2, 32'd2);
        for (int j = 0; j <= 9; j++) begin
            if (j > 0) @(negedge clk);
            exp = (j == 0 || ((j - 1) / 3) % 2 == 1) ? 4'hF : 4'h0;
            n_cmp++;
            if (out_port !== exp) begin
                n_bad++; $display("FAIL period_h2 j%0d: out_port=%h expected %h", j, out_port, exp);
            end
        end
        wr(2'd1, 32'd0);
    endtask

    task automatic test_cadence();
        int highs;
        int guard;
        wr(2'd2, 32'd1); wr(2'd3, 32'h0002_0001); wr(2'd1, 32'd3);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_port !== m_out[3:0]) begin
                n_bad++; $display("FAIL cadence k%0d: out_port=%h expected %h", k, out_port, m_out[3:0]);
            end
        end
        highs = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_port != 4'h0) highs++;
        end
        n_cmp++;
        if (highs !== 16) begin
            n_bad++; $display("FAIL cadence_duty: high cycles=%0d expected 16 of 80", highs);
        end
        guard = 0;
        while (model_gate() && guard < 40) begin
            @(negedge clk); guard++;
        end
        n_cmp++;
        if (guard >= 40) begin
            n_bad++; $display("FAIL cadence_wait_off: no OFF phase within 40 cycles");
        end
        @(negedge clk);
        wr(2'd3, 32'h0002_0001);
        highs = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (out_port != 4'h0) highs++;
            n_cmp++;
            if (out_port !== m_out[3:0]) begin
                n_bad++; $display("FAIL cadence_restart j%0d: out_port=%h expected %h", j, out_port, m_out[3:0]);
            end
        end
        n_cmp++;
        if (highs !== 4) begin
            n_bad++; $display("FAIL cadence_restart_on: high cycles=%0d expected 4 of 8", highs);
        end
        wr(2'd1, 32'd0);
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp;
        wr(2'd2, 32'd3); wr(2'd1, 32'd1);
        repeat (3) @(negedge clk);
        // Lands on the edge where cnt==3 would toggle phase.
        wr(2'd2, 32'd3);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            exp = (k == 5) ? 4'hF : 4'h0;
            n_cmp++;
            if (out_port !== exp) begin
                n_bad++; $display("FAIL simul_half k%0d: out_port=%h expected %h", k, out_port, exp);
            end
        end
    endtask

    task automatic test_ignored_writes();
        logic [31:0] exp [4];
        exp[0] = 32'h0000_000F; exp[1] = 32'h0000_0001;
        exp[2] = 32'h0000_0003; exp[3] = 32'h0002_0001;
        for (int a = 0; a < 4; a++) begin
            address = a[1:0]; writedata = $urandom; chipselect = 1'b0; write_n = 1'b0;
            @(negedge clk);
            address = a[1:0]; writedata = $urandom; chipselect = 1'b1; write_n = 1'b1;
            @(negedge clk);
        end
        chipselect = 1'b0; write_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = a[1:0]; #1;
            n_cmp++;
            if (readdata !== exp[a]) begin
                n_bad++; $display("FAIL ignored a%0d: readdata=%h expected %h", a, readdata, exp[a]);
            end
        end
        wr(2'd3, 32'hAB05_CD04);
        exp[3] = 32'h0005_0004;
        for (int a = 0; a < 4; a++) begin
            address = a[1:0]; #1;
            n_cmp++;
            if (readdata !== exp[a]) begin
                n_bad++; $display("FAIL addr_decode a%0d: readdata=%h expected %h", a, readdata, exp[a]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        wr(2'd2, 32'd1); wr(2'd1, 32'd1);
        guard = 0;
        while (m_out[3:0] == 4'h0 && guard < 10) begin
            @(negedge clk); guard++;
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (out_port !== 4'h0) begin
            n_bad++; $display("FAIL reset_async: out_port=%h expected 0", out_port);
        end
        for (int a = 0; a < 4; a++) begin
            address = a[1:0]; #1;
            n_cmp++;
            if (readdata !== 32'd0) begin
                n_bad++; $display("FAIL reset_mid_read a%0d: readdata=%h expected 0", a, readdata);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        wr(2'd0, 32'hF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_port !== 4'hF) begin
                n_bad++; $display("FAIL reset_tone_off k%0d: out_port=%h expected f", k, out_port);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  a;
        logic [31:0] d;
        int          r;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_port !== m_out[3:0]) begin
                n_bad++; $display("FAIL random_out i%0d: out_port=%h expected %h", i, out_port, m_out[3:0]);
            end
            a = 2'($urandom_range(0, 3));
            case (a)
                2'd0:    d = $urandom;
                2'd1:    d = ($urandom & 32'hFFFF_FFFE) | 32'(($urandom_range(0, 9) < 7) ? 1 : 0);
                2'd2:    d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 4);
                default: d = ($urandom & 32'hFF00_FF00) | ($urandom_range(0, 3) << 16) | $urandom_range(0, 3);
            endcase
            r = $urandom_range(0, 99);
            address    = a;
            writedata  = d;
            chipselect = (r < 30);
            write_n    = !(r < 20 || (r >= 30 && r < 40));
            #1;
            n_cmp++;
            if (readdata !== model_read(a)) begin
                n_bad++; $display("FAIL random_read i%0d a%0d: readdata=%h expected %h", i, a, readdata, model_read(a));
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_static();
        test_tone_half0();
        test_period();
        test_cadence();
        test_simultaneous();
        test_ignored_writes();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
